all_gates: RTL and testbench
============================

# all_gates

Two-input reference logic block that evaluates the seven basic Boolean functions (AND, OR, NOT, NAND, NOR, XOR, XNOR) of inputs `a` and `b` and exposes each as a discrete output and as a packed vector. A small clocked monitor counts input changes. It is the leaf-level gate library and bring-up target for the project, used to sanity-check tool flow and bench infrastructure.

## Interface
Parameters:
- `CNT_W`, default 8, width of the input-change counter (valid range 2..32).

Ports:
- `clk`  input  1  single system clock; all state is on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a`  input  1  operand A; also the NOT operand.
- `b`  input  1  operand B.
- `and_out`  output  1  a & b.
- `or_out`  output  1  a | b.
- `not_out`  output  1  ~a. `b` is ignored.
- `nand_out`  output  1  ~(a & b).
- `nor_out`  output  1  ~(a | b).
- `xor_out`  output  1  a ^ b.
- `xnor_out`  output  1  ~(a ^ b).
- `gates_vec`  output  7  packed copy of the gate outputs: bit0 AND, bit1 OR, bit2 NOT, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
- `change_cnt`  output  CNT_W  number of clock edges at which {a,b} differed from its previous sampled value.
- `cnt_sat`  output  1  high when `change_cnt` is at all-ones.

## Operation
- Gate outputs are pure functions of the current `a`, `b`. There is no enable and no handshake.
- `gates_vec` is always bit-identical to the seven discrete outputs.
- Monitor: on each rising `clk`, `{a,b}` is sampled into `ab_q`. If the new sample differs from `ab_q`, `change_cnt` increments by 1.
- `change_cnt` saturates at 2^CNT_W-1 and never wraps.
- `cnt_sat` is combinational from `change_cnt == all-ones`.
- The first edge after reset compares against the reset value of `ab_q`, which is 2'b00. An input of {0,0} therefore does not count; any other value counts once.
- X or Z on `a` or `b` propagates to the gate outputs unmasked. No sanitising is performed.

## Timing
- Default build: gate outputs are combinational, with zero-cycle latency from `a` and `b`. They are unaffected by `rst_n`.
- `rst_n` low, asynchronously: `ab_q` = 2'b00, `change_cnt` = 0, `cnt_sat` = 0.
- Reset deassertion: counting resumes at the first rising `clk` after `rst_n` is high.
- Reset asserted mid-operation clears the counter immediately, regardless of saturation state.
- An input change between clock edges that returns to its prior value before the next edge is not counted.

## Configuration
- Macro: `ALL_GATES_REG_OUT_EN`.
- Defined: all seven gate outputs and `gates_vec` are registered on rising `clk`, giving 1-cycle latency from `a`/`b`. While `rst_n` is low they are forced to 0, including `not_out`, `nand_out`, `nor_out` and `xnor_out`. The first valid values appear at the first edge after reset release.
- Not defined: gate outputs are combinational as above and do not depend on `clk` or `rst_n`.
- The monitor is identical in both builds.

## Structure
- Shared package `all_gates_pkg` holds:
  - the `gates_vec` bit-index constants `GATE_AND`..`GATE_XNOR` (0..6);
  - `GATE_NUM` = 7;
  - a typedef for the 7-bit gate vector.
- One combinational sub-module, `all_gates_logic` (inputs `a`, `b`; output a 7-bit vector), computes all seven functions.
- The top level contains the optional output register stage, the discrete-port fan-out and the change monitor.

## Test plan
- Default build, combinational truth table, steps every 10 time units:
  - a=0,b=0 -> AND0 OR0 NOT1 NAND1 NOR1 XOR0 XNOR1.
  - a=0,b=1 -> 0 1 1 1 0 1 0.
  - a=1,b=0 -> 0 1 0 1 0 1 0.
  - a=1,b=1 -> 1 1 0 0 0 0 1.
  - At every step, `gates_vec` equals the packed discrete outputs.
- Monitor counting: reset, then apply 00,01,10,11 on successive edges -> `change_cnt` = 3.
- Hold {a,b} constant for 10 edges -> `change_cnt` stays unchanged.
- Saturation with CNT_W=2: toggle `a` every edge for 6 edges -> `change_cnt` = 3 and `cnt_sat` = 1, with no wrap.
- Asynchronous reset: assert `rst_n`=0 between edges with `change_cnt`=5 -> `change_cnt` reads 0 immediately. Gate outputs keep tracking a/b in the default build.
- With `ALL_GATES_REG_OUT_EN`: during reset all gate outputs = 0. After release, apply a=1,b=1 -> AND=1 and XNOR=1 one clock edge later, not before.

Source files
------------

// File: rtl/all_gates_pkg.sv
// rtl/all_gates_pkg.sv - gate vector bit positions and type for all_gates
package all_gates_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int GATE_NUM  = 7;

  typedef logic [GATE_NUM-1:0] gate_vec_t;

endpackage

// File: rtl/all_gates_if.sv
// rtl/all_gates_if.sv - operand and result bundle for all_gates
interface all_gates_if #(
  parameter int CNT_W = 8
);
  import all_gates_pkg::*;

  logic             a;
  logic             b;
  logic             and_out;
  logic             or_out;
  logic             not_out;
  logic             nand_out;
  logic             nor_out;
  logic             xor_out;
  logic             xnor_out;
  gate_vec_t        gates_vec;
  logic [CNT_W-1:0] change_cnt;
  logic             cnt_sat;

  modport master (
    output a, b,
    input  and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
    input  gates_vec, change_cnt, cnt_sat
  );

  modport slave (
    input  a, b,
    output and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
    output gates_vec, change_cnt, cnt_sat
  );

endinterface

// File: rtl/all_gates_logic.sv
// rtl/all_gates_logic.sv - combinational evaluation of the seven basic gates
module all_gates_logic
  import all_gates_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t gates
);

  // Plain operators so X/Z on the operands reaches the outputs unmasked.
  always_comb begin
    gates            = '0;
    gates[GATE_AND]  = a & b;
    gates[GATE_OR]   = a | b;
    gates[GATE_NOT]  = ~a;
    gates[GATE_NAND] = ~(a & b);
    gates[GATE_NOR]  = ~(a | b);
    gates[GATE_XOR]  = a ^ b;
    gates[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/all_gates.sv
// rtl/all_gates.sv - gate library top with change monitor; ALL_GATES_REG_OUT_EN registers outputs
module all_gates
  import all_gates_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             and_out,
  output logic             or_out,
  output logic             not_out,
  output logic             nand_out,
  output logic             nor_out,
  output logic             xor_out,
  output logic             xnor_out,
  output gate_vec_t        gates_vec,
  output logic [CNT_W-1:0] change_cnt,
  output logic             cnt_sat
);

  gate_vec_t  comb_vec;
  logic [1:0] ab_q;

  all_gates_logic u_logic (
    .a     (a),
    .b     (b),
    .gates (comb_vec)
  );

`ifdef ALL_GATES_REG_OUT_EN
  gate_vec_t vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= comb_vec;
    end
  end

  assign gates_vec = vec_q;
`else
  assign gates_vec = comb_vec;
`endif

  assign and_out  = gates_vec[GATE_AND];
  assign or_out   = gates_vec[GATE_OR];
  assign not_out  = gates_vec[GATE_NOT];
  assign nand_out = gates_vec[GATE_NAND];
  assign nor_out  = gates_vec[GATE_NOR];
  assign xor_out  = gates_vec[GATE_XOR];
  assign xnor_out = gates_vec[GATE_XNOR];

  assign cnt_sat = &change_cnt;

  // Counter holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q       <= 2'b00;
      change_cnt <= '0;
    end else begin
      ab_q <= {a, b};
      if (({a, b} != ab_q) && !cnt_sat) begin
        change_cnt <= change_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_all_gates.sv
// tb/tb_all_gates.sv - directed self-checking bench for all_gates
module tb_all_gates;
  import all_gates_pkg::*;

  localparam gate_vec_t V00 = 7'b1011100;
  localparam gate_vec_t V01 = 7'b0101110;
  localparam gate_vec_t V10 = 7'b0101010;
  localparam gate_vec_t V11 = 7'b1000011;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  all_gates_if #(.CNT_W(8)) if8 ();
  all_gates_if #(.CNT_W(2)) if2 ();

  all_gates #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(if8.a), .b(if8.b),
    .and_out(if8.and_out), .or_out(if8.or_out), .not_out(if8.not_out),
    .nand_out(if8.nand_out), .nor_out(if8.nor_out), .xor_out(if8.xor_out),
    .xnor_out(if8.xnor_out), .gates_vec(if8.gates_vec),
    .change_cnt(if8.change_cnt), .cnt_sat(if8.cnt_sat)
  );

  all_gates #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(if2.a), .b(if2.b),
    .and_out(if2.and_out), .or_out(if2.or_out), .not_out(if2.not_out),
    .nand_out(if2.nand_out), .nor_out(if2.nor_out), .xor_out(if2.xor_out),
    .xnor_out(if2.xnor_out), .gates_vec(if2.gates_vec),
    .change_cnt(if2.change_cnt), .cnt_sat(if2.cnt_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ab(input logic av, input logic bv);
    if8.a = av; if8.b = bv;
    if2.a = av; if2.b = bv;
  endtask

  task automatic chk_gates(input string tag, input gate_vec_t exp);
    chk({tag, "_vec"}, 32'(if8.gates_vec), 32'(exp));
    chk({tag, "_disc"}, 32'({if8.xnor_out, if8.xor_out, if8.nor_out, if8.nand_out,
                             if8.not_out, if8.or_out, if8.and_out}), 32'(exp));
  endtask

  // Wait until a freshly applied operand is visible on the outputs.
  task automatic settle();
`ifdef ALL_GATES_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    set_ab(1'b0, 1'b0);
    #1;
    chk("rst_cnt", 32'(if8.change_cnt), 32'd0);
    chk("rst_sat", 32'(if8.cnt_sat), 32'd0);
`ifdef ALL_GATES_REG_OUT_EN
    chk_gates("rst_gates", 7'b0);
`else
    chk_gates("rst_gates", V00);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    set_ab(1'b0, 1'b0); settle(); chk_gates("tt00", V00);
    @(negedge clk); set_ab(1'b0, 1'b1); settle(); chk_gates("tt01", V01);
    @(negedge clk); set_ab(1'b1, 1'b0); settle(); chk_gates("tt10", V10);
    @(negedge clk); set_ab(1'b1, 1'b1); settle(); chk_gates("tt11", V11);

    // Monitor: 00,01,10,11 from a clean reset gives three changes.
    @(negedge clk);
    rst_n = 1'b0;
    set_ab(1'b0, 1'b0);
    #1 chk("rst2_cnt", 32'(if8.change_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    edges(1); set_ab(1'b0, 1'b1);
    edges(1); set_ab(1'b1, 1'b0);
    edges(1); set_ab(1'b1, 1'b1);
    edges(1);
    chk("cnt_seq", 32'(if8.change_cnt), 32'd3);

    edges(10);
    chk("cnt_hold", 32'(if8.change_cnt), 32'd3);

    set_ab(1'b0, 1'b1); edges(1);
    set_ab(1'b1, 1'b1); edges(1);
    chk("cnt_five", 32'(if8.change_cnt), 32'd5);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 chk("async_cnt", 32'(if8.change_cnt), 32'd0);
    set_ab(1'b1, 1'b0);
    #1;
`ifdef ALL_GATES_REG_OUT_EN
    chk_gates("rst_track", 7'b0);
`else
    chk_gates("rst_track", V10);
`endif

    // Output latency after release: 10 sampled first, then 11.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); set_ab(1'b1, 1'b1);
    #1;
`ifdef ALL_GATES_REG_OUT_EN
    chk("lat_and_early", 32'(if8.and_out), 32'd0);
    chk("lat_xnor_early", 32'(if8.xnor_out), 32'd0);
    @(posedge clk); #1;
`endif
    chk("lat_and", 32'(if8.and_out), 32'd1);
    chk("lat_xnor", 32'(if8.xnor_out), 32'd1);

    // Saturation on the 2-bit instance: six toggles of a.
    @(negedge clk);
    rst_n = 1'b0;
    set_ab(1'b0, 1'b0);
    #1 chk("sat_rst", 32'(if2.change_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    set_ab(1'b1, 1'b0); edges(1);
    set_ab(1'b0, 1'b0); edges(1);
    chk("sat_two", 32'(if2.change_cnt), 32'd2);
    chk("sat_two_flag", 32'(if2.cnt_sat), 32'd0);
    set_ab(1'b1, 1'b0); edges(1);
    chk("sat_three", 32'(if2.change_cnt), 32'd3);
    chk("sat_three_flag", 32'(if2.cnt_sat), 32'd1);
    set_ab(1'b0, 1'b0); edges(1);
    set_ab(1'b1, 1'b0); edges(1);
    set_ab(1'b0, 1'b0); edges(1);
    chk("sat_hold", 32'(if2.change_cnt), 32'd3);
    chk("sat_hold_flag", 32'(if2.cnt_sat), 32'd1);
    chk("wide_six", 32'(if8.change_cnt), 32'd6);
    chk("wide_flag", 32'(if8.cnt_sat), 32'd0);

    // A pulse that returns before the next edge is not counted.
    set_ab(1'b1, 1'b0);
    #2 set_ab(1'b0, 1'b0);
    edges(1);
    chk("glitch", 32'(if8.change_cnt), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
